// File: rtl/hub_port.sv
// hub_port: one cog's port onto the shared hub bus.
// A request is latched in IDLE, presented on the bus during this
// cog's slot (ISSUE), and completed by the hub acknowledge (WAIT).
//
// Ports
//   clk_cog, nres            clock, synchronous active-low reset
//   ena_bus, bus_sel         hub window strobe, this cog's slot
//   req, op_w, op_load,      request and its operands
//   op_s, op_a, op_d
//   busy, done, err          status (done/err are 1-clock pulses)
//   rsp_q, rsp_c             captured hub data / flag
//   bus_r/e/w/s/a/d          hub request lines (wired-OR, 0 unless driving)
//   bus_q, bus_c, bus_ack    hub response
//
// Optional: define HUB_PORT_TIMEOUT_EN to abort WAIT after TIMEOUT
// ena_bus pulses without an acknowledge (err and done pulse together).

module hub_port #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk_cog,
    input  logic        nres,
    input  logic        ena_bus,
    input  logic        bus_sel,
    input  logic        req,
    input  logic        op_w,
    input  logic        op_load,
    input  logic [1:0]  op_s,
    input  logic [15:0] op_a,
    input  logic [31:0] op_d,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rsp_q,
    output logic        rsp_c,
    output logic        bus_r,
    output logic        bus_e,
    output logic        bus_w,
    output logic [1:0]  bus_s,
    output logic [15:0] bus_a,
    output logic [31:0] bus_d,
    input  logic [31:0] bus_q,
    input  logic        bus_c,
    input  logic        bus_ack
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_t;

    state_t      state_q, state_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [31:0] rsp_q_q, rsp_q_d;
    logic        rsp_c_q, rsp_c_d;

    logic        w_q, w_d;
    logic        load_q, load_d;
    logic [1:0]  s_q, s_d;
    logic [15:0] a_q, a_d;
    logic [31:0] d_q, d_d;

    logic        accept;
    logic        xfer;
    logic        ack_ok;
    logic        expire;
    logic        drive;

    // A request seen during the done pulse is left for the next clock.
    assign accept = (state_q == IDLE) && req && !done_q;
    assign xfer   = (state_q == ISSUE) && ena_bus && bus_sel;
    assign ack_ok = (state_q == WAIT) && ena_bus && bus_ack;

`ifdef HUB_PORT_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;

    // Fires on the TIMEOUT-th window in WAIT; an ack on that window wins.
    assign expire = (state_q == WAIT) && ena_bus && !bus_ack
                    && (cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q;
        err_d = 1'b0;
        if (xfer) begin
            cnt_d = '0;
        end else if ((state_q == WAIT) && ena_bus) begin
            cnt_d = cnt_q + CW'(1);
        end
        if (expire) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_cog) begin
        if (!nres) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    logic [31:0] timeout_unused;

    assign timeout_unused = TIMEOUT;
    assign expire         = 1'b0;
    assign err            = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        rsp_q_d = rsp_q_q;
        rsp_c_d = rsp_c_q;
        w_d     = w_q;
        load_d  = load_q;
        s_d     = s_q;
        a_d     = a_q;
        d_d     = d_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    w_d     = op_w;
                    load_d  = op_load;
                    s_d     = op_s;
                    a_d     = op_a;
                    d_d     = op_d;
                    busy_d  = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (xfer) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (ack_ok) begin
                    rsp_q_d = bus_q;
                    rsp_c_d = bus_c;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (expire) begin
                    rsp_q_d = 32'h0;
                    rsp_c_d = 1'b0;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_cog) begin
        if (!nres) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rsp_q_q <= 32'h0;
            rsp_c_q <= 1'b0;
            w_q     <= 1'b0;
            load_q  <= 1'b0;
            s_q     <= 2'b00;
            a_q     <= 16'h0;
            d_q     <= 32'h0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rsp_q_q <= rsp_q_d;
            rsp_c_q <= rsp_c_d;
            w_q     <= w_d;
            load_q  <= load_d;
            s_q     <= s_d;
            a_q     <= a_d;
            d_q     <= d_d;
        end
    end

    // Lines are wired-OR with other cogs, so stay zero off-slot.
    // Size 2'b11 is a system op and never writes.
    assign drive = (state_q == ISSUE) && bus_sel;
    assign bus_e = drive;
    assign bus_w = drive && w_q && (s_q != 2'b11);
    assign bus_r = drive && !load_q;
    assign bus_s = drive ? s_q : 2'b00;
    assign bus_a = drive ? a_q : 16'h0;
    assign bus_d = drive ? d_q : 32'h0;

    assign busy  = busy_q;
    assign done  = done_q;
    assign rsp_q = rsp_q_q;
    assign rsp_c = rsp_c_q;

endmodule

// File: tb/tb_hub_port.sv
// tb_hub_port: self-checking bench for hub_port.
// Table-driven transactions with a response scoreboard plus corner sequences.

module tb_hub_port;

    logic        clk_cog = 1'b0;
    logic        nres    = 1'b0;
    logic        ena_bus = 1'b0;
    logic        bus_sel = 1'b0;
    logic        req     = 1'b0;
    logic        op_w    = 1'b0;
    logic        op_load = 1'b0;
    logic [1:0]  op_s    = 2'b00;
    logic [15:0] op_a    = 16'h0;
    logic [31:0] op_d    = 32'h0;
    logic        busy, done, err;
    logic [31:0] rsp_q;
    logic        rsp_c;
    logic        bus_r, bus_e, bus_w;
    logic [1:0]  bus_s;
    logic [15:0] bus_a;
    logic [31:0] bus_d;
    logic [31:0] bus_q   = 32'h0;
    logic        bus_c   = 1'b0;
    logic        bus_ack = 1'b0;

    hub_port #(.TIMEOUT(4)) dut (
        .clk_cog (clk_cog),
        .nres    (nres),
        .ena_bus (ena_bus),
        .bus_sel (bus_sel),
        .req     (req),
        .op_w    (op_w),
        .op_load (op_load),
        .op_s    (op_s),
        .op_a    (op_a),
        .op_d    (op_d),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .rsp_q   (rsp_q),
        .rsp_c   (rsp_c),
        .bus_r   (bus_r),
        .bus_e   (bus_e),
        .bus_w   (bus_w),
        .bus_s   (bus_s),
        .bus_a   (bus_a),
        .bus_d   (bus_d),
        .bus_q   (bus_q),
        .bus_c   (bus_c),
        .bus_ack (bus_ack)
    );

    always #5 clk_cog = ~clk_cog;

    typedef struct {
        logic        w;
        logic        load;
        logic [1:0]  s;
        logic [15:0] a;
        logic [31:0] d;
        logic [31:0] q;
        logic        c;
        int          dly;
        logic        ew;
        logic        er;
    } vec_t;

    typedef struct {
        logic [31:0] q;
        logic        c;
    } rsp_t;

    vec_t tbl[5];
    rsp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    task automatic tick;
        @(posedge clk_cog);
        #1;
    endtask

    function automatic logic bus_any();
        return bus_r | bus_e | bus_w | (|bus_s) | (|bus_a) | (|bus_d);
    endfunction

    // Full transaction; returns right after the completion edge.
    task automatic run_op(input vec_t v);
        int   lat;
        rsp_t e;
        op_w = v.w; op_load = v.load; op_s = v.s;
        op_a = v.a; op_d = v.d;
        req = 1'b1; bus_sel = 1'b0; ena_bus = 1'b1;
        tick;
        req = 1'b0;
        op_w = ~v.w; op_a = ~v.a; op_d = ~v.d;
        chk("busy_set", busy, 1);
        chk("bus_off_nosel", bus_any(), 0);
        bus_sel = 1'b1; ena_bus = 1'b0;
        #1;
        chk("bus_e", bus_e, 1);
        chk("bus_w", bus_w, v.ew);
        chk("bus_r", bus_r, v.er);
        chk("bus_s", bus_s, v.s);
        chk("bus_a", bus_a, v.a);
        chk("bus_d", bus_d, v.d);
        tick;
        chk("issue_hold", bus_e, 1);
        ena_bus = 1'b1;
        tick;
        e.q = v.q; e.c = v.c;
        sb.push_back(e);
        chk("bus_off_wait", bus_any(), 0);
        lat = 0;
        for (int k = 1; k <= v.dly + 2 && lat == 0; k++) begin
            bus_ack = (k == v.dly);
            bus_q   = (k == v.dly) ? v.q : 32'hBAD00000 + k;
            bus_c   = (k == v.dly) ? v.c : ~v.c;
            tick;
            if (done) lat = k;
        end
        bus_ack = 1'b0; bus_sel = 1'b0;
        chk("latency", lat, v.dly);
        e = sb.pop_front();
        chk("rsp_q", rsp_q, e.q);
        chk("rsp_c", rsp_c, e.c);
        chk("busy_clr", busy, 0);
        chk("err_lo", err, 0);
    endtask

    initial begin
        int ndone;

        //        w     load  s      a         d             q             c     dly ew    er
        tbl[0] = '{1'b0, 1'b0, 2'b10, 16'h0104, 32'h0,        32'hDEADBEEF, 1'b0, 1, 1'b0, 1'b1};
        tbl[1] = '{1'b1, 1'b0, 2'b00, 16'h0003, 32'h000000A5, 32'h12345678, 1'b0, 3, 1'b1, 1'b1};
        tbl[2] = '{1'b1, 1'b0, 2'b11, 16'h0006, 32'h00000001, 32'h00000005, 1'b1, 2, 1'b0, 1'b1};
        tbl[3] = '{1'b0, 1'b1, 2'b10, 16'h0ABC, 32'h0,        32'hCAFEF00D, 1'b1, 4, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 1'b0, 2'b01, 16'h1002, 32'h0000BEEF, 32'h0000BEEF, 1'b0, 2, 1'b1, 1'b1};

        // reset state, with hub noise present
        nres = 1'b0; bus_sel = 1'b1; ena_bus = 1'b1;
        bus_ack = 1'b1; bus_q = '1; bus_c = 1'b1;
        repeat (2) tick;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_rsp_q", rsp_q, 0);
        chk("rst_rsp_c", rsp_c, 0);
        chk("rst_bus", bus_any(), 0);
        nres = 1'b1;
        tick;
        chk("idle_ack_ignored", done, 0);
        bus_ack = 1'b0; bus_sel = 1'b0; bus_c = 1'b0;
        tick;

        for (int i = 0; i < 5; i++) begin
            run_op(tbl[i]);
            tick;
            chk("done_pulse", done, 0);
            chk("rsp_hold", rsp_q, tbl[i].q);
        end

        // req during the done clock is refused, then taken
        run_op(tbl[0]);
        op_w = 1'b0; op_load = 1'b0; op_s = 2'b10; op_a = 16'h0200;
        req = 1'b1;
        tick;
        chk("req_on_done", busy, 0);
        tick;
        chk("req_after_done", busy, 1);
        req = 1'b0; bus_sel = 1'b1; ena_bus = 1'b1;
        tick;
        // reset in WAIT, then a late ack
        nres = 1'b0;
        tick;
        nres = 1'b1; bus_ack = 1'b1; bus_q = 32'h11111111;
        ndone = 0;
        for (int k = 0; k < 3; k++) begin
            tick;
            if (done) ndone++;
        end
        chk("rst_wait_done", ndone, 0);
        chk("rst_wait_busy", busy, 0);
        chk("rst_wait_bus", bus_any(), 0);
        chk("rst_wait_rsp", rsp_q, 0);
        bus_ack = 1'b0; bus_sel = 1'b0;
        tick;

        // second req while busy is ignored
        op_w = 1'b0; op_s = 2'b10; op_a = 16'h0104; op_d = 0;
        req = 1'b1; ena_bus = 1'b0;
        tick;
        op_a = 16'h7777; op_s = 2'b00; bus_sel = 1'b1;
        #1;
        chk("busy_req_a", bus_a, 16'h0104);
        tick;
        chk("busy_req_a2", bus_a, 16'h0104);
        chk("busy_req_s", bus_s, 2'b10);
        ena_bus = 1'b1;
        tick;
        repeat (2) tick;
        req = 1'b0; bus_ack = 1'b1; bus_q = 32'h0BADCAFE; bus_c = 1'b0;
        ndone = 0;
        for (int k = 0; k < 4; k++) begin
            tick;
            bus_ack = 1'b0;
            if (done) ndone++;
        end
        chk("single_done", ndone, 1);
        chk("single_rsp", rsp_q, 32'h0BADCAFE);
        bus_sel = 1'b0;
        tick;

        // WAIT with no acknowledge
        op_a = 16'h0040; op_s = 2'b10;
        req = 1'b1; ena_bus = 1'b0;
        tick;
        req = 1'b0; bus_sel = 1'b1; ena_bus = 1'b1;
        tick;
        bus_sel = 1'b0;
`ifdef HUB_PORT_TIMEOUT_EN
        for (int p = 1; p <= 4; p++) begin
            ena_bus = 1'b0;
            tick;
            chk("to_gap_done", done, 0);
            ena_bus = 1'b1;
            tick;
            if (p < 4) begin
                chk("to_early_err", err, 0);
                chk("to_early_done", done, 0);
            end
        end
        chk("to_err", err, 1);
        chk("to_done", done, 1);
        chk("to_rsp_q", rsp_q, 0);
        chk("to_rsp_c", rsp_c, 0);
        chk("to_busy", busy, 0);
        tick;
        chk("to_err_pulse", err, 0);
`else
        ndone = 0;
        for (int k = 0; k < 40; k++) begin
            ena_bus = k[0];
            tick;
            if (done || err) ndone++;
        end
        chk("noto_done", ndone, 0);
        chk("noto_busy", busy, 1);
        ena_bus = 1'b1; bus_ack = 1'b1; bus_q = 32'h00C0FFEE;
        tick;
        bus_ack = 1'b0;
        chk("noto_ack_done", done, 1);
        chk("noto_err", err, 0);
        chk("noto_rsp", rsp_q, 32'h00C0FFEE);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
